// File: rtl/rs232_uart.sv
// rs232_uart: 8N1 RS232 transceiver. Frames are LSB first and the line is idle high.
//
// The transmitter and receiver are independent FSMs. Each FSM has its own
// bit-time counter and its own 3-bit bit-index counter.
//
// Ports
//   clk           system clock; all logic runs on the rising edge
//   rst_n         asynchronous active-low reset
//   rx            serial line in; asynchronous to clk
//   tx            serial line out; idle high
//   tx_data[7:0]  byte to send; captured only when tx_start is accepted
//   tx_start      send request; ignored while tx_busy is high
//   tx_busy       high for the 10 bit times of a frame
//   tx_done       one-cycle pulse at the end of the stop bit
//   rx_data[7:0]  last correctly framed byte
//   rx_valid      one-cycle pulse when rx_data is updated
//   rx_frame_err  one-cycle pulse when the stop bit is sampled low
module rs232_uart #(
    parameter int unsigned CLKS_PER_BIT = 870,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ---------------- receiver ----------------
    logic          rx_meta_q, rx_sync_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q, rx_ferr_d;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_st_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    rx_st_d  = ST_START;
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    // A line already back high at mid start bit is a glitch.
                    rx_cnt_d = '0;
                    rx_st_d  = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_idx_d = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) rx_st_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin // ST_STOP
                if (rx_cnt_q == CNT_LAST) begin
                    // Return to IDLE at mid stop bit so a start edge that
                    // follows straight away is not missed.
                    rx_cnt_d = '0;
                    rx_st_d  = ST_IDLE;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_ferr_d  = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_st_q    <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;

    // ---------------- transmitter ----------------
    logic [1:0]    tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic          tx_done_q, tx_done_d;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_cnt_d  = tx_cnt_q;
        tx_idx_d  = tx_idx_q;
        tx_sh_d   = tx_sh_q;
        tx_d      = tx_q;
        tx_busy_d = tx_busy_q;
        tx_done_d = 1'b0;
        case (tx_st_q)
            ST_IDLE: begin
                tx_d      = 1'b1;
                tx_busy_d = 1'b0;
                if (tx_start) begin
                    tx_sh_d   = tx_data;
                    tx_cnt_d  = '0;
                    tx_idx_d  = '0;
                    tx_st_d   = ST_START;
                    tx_d      = 1'b0;
                    tx_busy_d = 1'b1;
                end
            end
            ST_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_st_d  = ST_DATA;
                    tx_d     = tx_sh_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_st_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // tx is registered, so the next bit is read one
                        // position ahead of the current shift.
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_d     = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin // ST_STOP
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d  = '0;
                    tx_st_d   = ST_IDLE;
                    tx_d      = 1'b1;
                    tx_busy_d = 1'b0;
                    tx_done_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q   <= ST_IDLE;
            tx_cnt_q  <= '0;
            tx_idx_q  <= '0;
            tx_sh_q   <= '0;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_idx_q  <= tx_idx_d;
            tx_sh_q   <= tx_sh_d;
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_rs232_uart.sv
// tb_rs232_uart: randomized self-checking bench for rs232_uart.
//
// A behavioural serial terminal drives rx. The tx line is compared cycle by
// cycle against an ideal 8N1 frame. A short bit time keeps the run small.
module tb_rs232_uart;

    localparam int CPB  = 32;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx;
    logic       tx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;

    assign rx = loop_en ? tx : rx_drv;

    always #10 clk = ~clk;

    rs232_uart #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Receive monitor
    logic [7:0] got_q[$];
    int ferr_cnt = 0;
    int both_cnt = 0;
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) got_q.push_back(rx_data);
            if (rx_frame_err) ferr_cnt++;
            if (rx_valid && rx_frame_err) both_cnt++;
        end
    end

    initial begin
        #(80000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ideal line level k cycles into a frame that carries byte d.
    function automatic logic fbit(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return d[b-1];
    endfunction

    // Terminal: send one 8N1 frame on rx.
    // A bad stop bit is released three quarters of the way through. The
    // receiver's re-armed start check then sees a high line instead of
    // another start bit.
    task automatic term_send(input logic [7:0] d, input bit bad_stop);
        for (int b = 0; b < 9; b++) begin
            rx_drv = (b == 0) ? 1'b0 : d[b-1];
            repeat (CPB) @(negedge clk);
        end
        if (bad_stop) begin
            rx_drv = 1'b0;
            repeat (3 * CPB / 4) @(negedge clk);
            rx_drv = 1'b1;
            repeat (CPB - 3 * CPB / 4) @(negedge clk);
        end else begin
            rx_drv = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Start one tx frame and record its deviations from the ideal waveform.
    // inj_at >= 0 applies a mid-frame tx_data change, with tx_start if inj_start.
    task automatic tx_frame(input logic [7:0] d, input int inj_at, input bit inj_start,
                            input logic [7:0] inj_d, output int errs, output int busy_cnt,
                            output int done_cnt, output int tail_errs);
        errs = 0; busy_cnt = 0; done_cnt = 0; tail_errs = 0;
        @(negedge clk);
        tx_data = d; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (tx !== fbit(d, k)) errs++;
            if (tx_busy === 1'b1) busy_cnt++;
            if (tx_done === 1'b1) done_cnt++;
            if (k == inj_at) begin
                tx_data = inj_d; tx_start = inj_start;
            end else if (k == inj_at + 1) begin
                tx_start = 1'b0;
            end
            @(negedge clk);
        end
        if (tx_done === 1'b1) done_cnt++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) tail_errs++;
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) tail_errs++;
            if (tx_done === 1'b1) done_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        vectors++; if (rx_frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_err); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got tx=%b busy=%b expected 1/0", tx, tx_busy); end
    endtask

    task automatic test_hello;
        logic [7:0] hello[11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                  8'h52, 8'h53, 8'h32, 8'h33, 8'h32};
        got_q.delete(); ferr_cnt = 0;
        for (int i = 0; i < 11; i++) term_send(hello[i], 1'b0);
        repeat (4) @(negedge clk);
        last_good = hello[10];
        vectors++; if (got_q.size() != 11) begin miscompares++; $display("FAIL hello_count: got %0d expected 11", got_q.size()); end
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (i >= got_q.size()) begin miscompares++; $display("FAIL hello_byte%0d: got none expected %h", i, hello[i]); end
            else if (got_q[i] !== hello[i]) begin miscompares++; $display("FAIL hello_byte%0d: got %h expected %h", i, got_q[i], hello[i]); end
        end
        vectors++; if (ferr_cnt != 0) begin miscompares++; $display("FAIL hello_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_frame_err;
        got_q.delete(); ferr_cnt = 0;
        term_send(8'hA5, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        vectors++; if (ferr_cnt != 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL ferr_no_valid: got %0d expected 0", got_q.size()); end
        vectors++; if (rx_data !== last_good) begin miscompares++; $display("FAIL ferr_rx_held: got %h expected %h", rx_data, last_good); end
        term_send(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        last_good = 8'h3C;
        vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin miscompares++; $display("FAIL ferr_recover: got n=%0d rx_data=%h expected 1 x 3c", got_q.size(), rx_data); end
        vectors++; if (ferr_cnt != 1) begin miscompares++; $display("FAIL ferr_recover_err: got %0d expected 1", ferr_cnt); end
    endtask

    task automatic test_glitch;
        got_q.delete(); ferr_cnt = 0;
        rx_drv = 1'b0;
        repeat (HALF - 6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        vectors++; if (got_q.size() != 0 || ferr_cnt != 0) begin miscompares++; $display("FAIL glitch_silent: got valid=%0d ferr=%0d expected 0/0", got_q.size(), ferr_cnt); end
        term_send(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        last_good = 8'h55;
        vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h55) begin miscompares++; $display("FAIL glitch_next_frame: got n=%0d rx_data=%h expected 1 x 55", got_q.size(), rx_data); end
    endtask

    task automatic test_random_rx;
        logic [7:0] exp_q[$];
        got_q.delete(); ferr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'($urandom_range(0, 255)));
            term_send(exp_q[i], 1'b0);
        end
        repeat (4) @(negedge clk);
        last_good = exp_q[7];
        vectors++; if (got_q.size() != 8) begin miscompares++; $display("FAIL rand_rx_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_rx_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        vectors++; if (rx_data !== last_good) begin miscompares++; $display("FAIL rand_rx_hold: got %h expected %h", rx_data, last_good); end
    endtask

    task automatic test_tx_h;
        int errs, busy_cnt, done_cnt, tail;
        tx_frame(8'h48, -1, 1'b0, 8'h00, errs, busy_cnt, done_cnt, tail);
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL tx_h_wave: got %0d bad cycles expected 0", errs); end
        vectors++; if (busy_cnt != 10 * CPB) begin miscompares++; $display("FAIL tx_h_busy: got %0d expected %0d", busy_cnt, 10 * CPB); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL tx_h_done: got %0d expected 1", done_cnt); end
        vectors++; if (tail != 0) begin miscompares++; $display("FAIL tx_h_idle: got %0d bad cycles expected 0", tail); end
    endtask

    task automatic test_tx_ignore;
        int errs, busy_cnt, done_cnt, tail;
        tx_frame(8'h41, 2 * CPB + 8, 1'b1, 8'hFF, errs, busy_cnt, done_cnt, tail);
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL tx_ignore_wave: got %0d bad cycles expected 0", errs); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL tx_ignore_done: got %0d expected 1", done_cnt); end
        vectors++; if (tail != 0) begin miscompares++; $display("FAIL tx_ignore_not_queued: got %0d bad cycles expected 0", tail); end
    endtask

    task automatic test_tx_data_change;
        int errs, busy_cnt, done_cnt, tail;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        tx_frame(d, 5 * CPB, 1'b0, ~d, errs, busy_cnt, done_cnt, tail);
        vectors++; if (errs != 0 || busy_cnt != 10 * CPB) begin miscompares++; $display("FAIL tx_data_change: got %0d bad cycles busy=%0d expected 0/%0d", errs, busy_cnt, 10 * CPB); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        logic exp_tx;
        int errs;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        errs = 0;
        @(negedge clk);
        tx_data = a; tx_start = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 20 * CPB; k++) begin
            if (k < 10 * CPB) exp_tx = fbit(a, k);
            else if (k == 10 * CPB) exp_tx = 1'b1;
            else exp_tx = fbit(b, k - 10 * CPB - 1);
            if (tx !== exp_tx) errs++;
            if (tx_busy !== (k != 10 * CPB)) errs++;
            if (tx_done !== (k == 10 * CPB)) errs++;
            if (k == 3) tx_data = b;
            if (k == 10 * CPB + 4) tx_start = 1'b0;
            @(negedge clk);
        end
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL b2b_wave: got %0d bad cycles expected 0", errs); end
        vectors++; if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got done=%b busy=%b expected 1/0", tx_done, tx_busy); end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int errs, busy_cnt, done_cnt, tail, rerr;
        rerr = 0;
        @(negedge clk);
        tx_data = 8'h00; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * CPB + 7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_async: got tx=%b busy=%b expected 1/0", tx, tx_busy); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) rerr++;
        end
        vectors++; if (rerr != 0) begin miscompares++; $display("FAIL rst_hold: got %0d bad cycles expected 0", rerr); end
        rst_n = 1'b1;
        last_good = 8'h00;
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
        repeat (2) @(negedge clk);
        tx_frame(8'h7E, -1, 1'b0, 8'h00, errs, busy_cnt, done_cnt, tail);
        vectors++; if (errs != 0 || done_cnt != 1 || tail != 0) begin miscompares++; $display("FAIL rst_then_7e: got errs=%0d done=%0d tail=%0d expected 0/1/0", errs, done_cnt, tail); end
    endtask

    task automatic test_loopback;
        int errs, busy_cnt, done_cnt, tail;
        logic [7:0] exp_q[$];
        got_q.delete(); ferr_cnt = 0;
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'($urandom_range(0, 255)));
            tx_frame(exp_q[i], -1, 1'b0, 8'h00, errs, busy_cnt, done_cnt, tail);
            vectors++; if (errs != 0) begin miscompares++; $display("FAIL loop_wave%0d: got %0d bad cycles expected 0", i, errs); end
        end
        loop_en = 1'b0;
        vectors++; if (got_q.size() != 4 || ferr_cnt != 0) begin miscompares++; $display("FAIL loop_count: got %0d ferr=%0d expected 4/0", got_q.size(), ferr_cnt); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL loop_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_full_duplex;
        int errs, busy_cnt, done_cnt, tail;
        logic [7:0] a, b;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        got_q.delete(); ferr_cnt = 0;
        fork
            tx_frame(a, -1, 1'b0, 8'h00, errs, busy_cnt, done_cnt, tail);
            begin
                repeat (7) @(negedge clk);
                term_send(b, 1'b0);
            end
        join
        vectors++; if (errs != 0 || done_cnt != 1) begin miscompares++; $display("FAIL duplex_tx: got errs=%0d done=%0d expected 0/1", errs, done_cnt); end
        vectors++; if (got_q.size() != 1 || got_q[0] !== b) begin miscompares++; $display("FAIL duplex_rx: got n=%0d rx_data=%h expected 1 x %h", got_q.size(), rx_data, b); end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_frame_err();
        test_glitch();
        test_random_rx();
        test_tx_h();
        test_tx_ignore();
        test_tx_data_change();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        test_full_duplex();
        vectors++; if (both_cnt != 0) begin miscompares++; $display("FAIL valid_and_ferr: got %0d overlaps expected 0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
